// File: rtl/pifo_calendar_pkg.sv
// Shared field layout, state encoding and root-word packing for the root PIFO
// calendar front-end controller.
package pifo_calendar_pkg;

  localparam int PIFO_CALENDAR_SIZE        = 1024;
  localparam int PIFO_CALENDAR_INDEX_WIDTH = 10;
  localparam int BUFFER_ADDR_WIDTH         = 12;
  localparam int PIFO_RANK_WIDTH           = 19;
  localparam int PIFO_ROOT_WIDTH           = 32;
  localparam int ROOT_RANK_START_POS       = 12;
  localparam int ROOT_PIFO_INFO_VALID_POS  = 31;
  localparam int CPU_WAIT_TIMEOUT          = 64;

  localparam int OCC_W      = PIFO_CALENDAR_INDEX_WIDTH + 1;
  localparam int WAIT_CNT_W = $clog2(CPU_WAIT_TIMEOUT);

  // Requester indices shared by the arbiter and the controller
  localparam int ENQ_IDX = 0;
  localparam int DEQ_IDX = 1;

  typedef enum logic [0:0] {
    ST_RUN      = 1'b0,
    ST_CPU_WAIT = 1'b1
  } ctrl_state_e;

  function automatic logic [PIFO_ROOT_WIDTH-1:0] pack_root(
    input logic [PIFO_RANK_WIDTH-1:0]   rank,
    input logic [BUFFER_ADDR_WIDTH-1:0] addr
  );
    logic [PIFO_ROOT_WIDTH-1:0] word;
    word = '0;
    word[ROOT_PIFO_INFO_VALID_POS] = 1'b1;
    word[ROOT_RANK_START_POS +: PIFO_RANK_WIDTH] = rank;
    word[BUFFER_ADDR_WIDTH-1:0] = addr;
    return word;
  endfunction

endpackage

// File: rtl/pifo_calendar_ctrl_rr_arbiter.sv
// Two-requester round-robin arbiter; the side served last loses a tie.
module pifo_rr_arbiter2
  import pifo_calendar_pkg::*;
(
  input  logic       clk,
  input  logic       rstn,
  input  logic [1:0] req,
  output logic [1:0] grant
);

  // Index of the requester that wins when both ask; starts out favouring dequeue
  logic prio;

  always_comb begin
    grant = req;
    if (req == 2'b11) begin
      grant = '0;
      grant[prio] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      prio <= 1'(DEQ_IDX);
    end else if (grant[ENQ_IDX]) begin
      prio <= 1'(DEQ_IDX);
    end else if (grant[DEQ_IDX]) begin
      prio <= 1'(ENQ_IDX);
    end
  end

endmodule

// File: rtl/pifo_calendar_ctrl.sv
// Root PIFO calendar front end: arbitrates enqueue/dequeue into insert/pop
// commands, tracks occupancy, yields to CPU writes and returns popped addresses.
module pifo_calendar_ctrl
  import pifo_calendar_pkg::*;
(
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         s_enq_valid,
  output logic                         s_enq_ready,
  input  logic [PIFO_RANK_WIDTH-1:0]   s_enq_rank,
  input  logic [BUFFER_ADDR_WIDTH-1:0] s_enq_buffer_addr,
  input  logic                         s_deq_valid,
  output logic                         s_deq_ready,
  output logic                         m_deq_valid,
  output logic [BUFFER_ADDR_WIDTH-1:0] m_deq_buffer_addr,
  output logic                         m_deq_error,
  output logic [PIFO_ROOT_WIDTH-1:0]   m_axis_pifo_info_root,
  output logic                         m_axis_insert_en,
  output logic                         m_axis_pop_en,
  input  logic [BUFFER_ADDR_WIDTH-1:0] s_axis_buffer_addr,
  input  logic                         s_axis_buffer_addr_valid,
  input  logic                         cpu_wr_pending,
  input  logic                         cpu_wr_result_valid,
  output logic                         cpu_wr_timeout,
  output logic [OCC_W-1:0]             occupancy,
  output logic                         calendar_full,
  output logic                         calendar_empty
);

  ctrl_state_e           state, state_next;
  logic [WAIT_CNT_W-1:0] wait_cnt;
  logic                  pending_mask;
  logic                  cpu_hold;
  logic                  timeout_hit;
  logic [1:0]            req, grant;

  // Right after a timeout the still-raised pending flag is ignored for one
  // cycle, so the datapath is guaranteed at least one slot of progress.
  assign cpu_hold       = cpu_wr_pending && !pending_mask;
  assign calendar_full  = (occupancy == OCC_W'(PIFO_CALENDAR_SIZE));
  assign calendar_empty = (occupancy == '0);
  assign s_enq_ready    = rstn && (state == ST_RUN) && !calendar_full  && !cpu_hold;
  assign s_deq_ready    = rstn && (state == ST_RUN) && !calendar_empty && !cpu_hold;

  always_comb begin
    req          = '0;
    req[ENQ_IDX] = s_enq_valid && s_enq_ready;
    req[DEQ_IDX] = s_deq_valid && s_deq_ready;
  end

  pifo_rr_arbiter2 u_arb (
    .clk   (clk),
    .rstn  (rstn),
    .req   (req),
    .grant (grant)
  );

  always_comb begin
    state_next  = state;
    timeout_hit = 1'b0;
    unique case (state)
      ST_RUN: begin
        if (cpu_hold) state_next = ST_CPU_WAIT;
      end
      ST_CPU_WAIT: begin
        if (cpu_wr_result_valid) begin
          state_next = ST_RUN;
        end else if (wait_cnt == WAIT_CNT_W'(CPU_WAIT_TIMEOUT - 1)) begin
          state_next  = ST_RUN;
          timeout_hit = 1'b1;
        end
      end
      default: state_next = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state          <= ST_RUN;
      wait_cnt       <= '0;
      pending_mask   <= 1'b0;
      cpu_wr_timeout <= 1'b0;
    end else begin
      state          <= state_next;
      wait_cnt       <= (state == ST_CPU_WAIT) ? wait_cnt + WAIT_CNT_W'(1) : '0;
      pending_mask   <= timeout_hit;
      cpu_wr_timeout <= timeout_hit;
    end
  end

  // The calendar head is sampled while pop_en is high, i.e. before it shifts
  always_ff @(posedge clk) begin
    if (!rstn) begin
      m_axis_insert_en      <= 1'b0;
      m_axis_pop_en         <= 1'b0;
      m_axis_pifo_info_root <= '0;
      occupancy             <= '0;
      m_deq_valid           <= 1'b0;
      m_deq_error           <= 1'b0;
      m_deq_buffer_addr     <= '0;
    end else begin
      m_axis_insert_en <= grant[ENQ_IDX];
      m_axis_pop_en    <= grant[DEQ_IDX];
      if (grant[ENQ_IDX]) begin
        m_axis_pifo_info_root <= pack_root(s_enq_rank, s_enq_buffer_addr);
        occupancy             <= occupancy + OCC_W'(1);
      end else if (grant[DEQ_IDX]) begin
        occupancy             <= occupancy - OCC_W'(1);
      end
      m_deq_valid <= m_axis_pop_en;
      m_deq_error <= m_axis_pop_en && !s_axis_buffer_addr_valid;
      if (m_axis_pop_en) m_deq_buffer_addr <= s_axis_buffer_addr;
    end
  end

endmodule
